// File: rtl/nvdla_rd_req_arb.sv
// Round-robin read-request arbiter feeding one registered MCIF request slot, with an
// order FIFO of {channel, size} used to steer in-order response beats back to their client.
module nvdla_rd_req_arb #(
  parameter int NUM_CH    = 3,
  parameter int AW        = 32,
  parameter int SW        = 15,
  parameter int RSP_W     = 65,
  parameter int ORD_DEPTH = 8
) (
  input  logic                             nvdla_core_clk,
  input  logic                             nvdla_core_rst,
  input  logic [NUM_CH-1:0]                ch_req_valid,
  output logic [NUM_CH-1:0]                ch_req_ready,
  input  logic [NUM_CH*(AW+SW)-1:0]        ch_req_pd,
  output logic                             mc_req_valid,
  input  logic                             mc_req_ready,
  output logic [AW+SW-1:0]                 mc_req_pd,
  input  logic                             mc_rsp_valid,
  output logic                             mc_rsp_ready,
  input  logic [RSP_W-1:0]                 mc_rsp_pd,
  output logic [NUM_CH-1:0]                ch_rsp_valid,
  input  logic [NUM_CH-1:0]                ch_rsp_ready,
  output logic [RSP_W-1:0]                 ch_rsp_pd,
  output logic [NUM_CH-1:0]                ch_cdt_lat_fifo_pop,
  output logic [$clog2(ORD_DEPTH+1)-1:0]   outstanding
);

  localparam int PW   = AW + SW;
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTRW = $clog2(ORD_DEPTH);
  localparam int OW   = $clog2(ORD_DEPTH + 1);
  localparam logic [CW:0] NCH_W = (CW+1)'(NUM_CH);

  logic            req_vld_q, req_vld_d;
  logic [PW-1:0]   req_pd_q;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]   ord_ch_q [ORD_DEPTH];
  logic [SW-1:0]   ord_sz_q [ORD_DEPTH];

  logic                  slot_free, ord_full, ord_empty, arb_en;
  logic [CW-1:0]         start, offset, grant_idx;
  logic [CW:0]           sum;
  logic [2*NUM_CH-1:0]   vld2;
  logic [NUM_CH-1:0]     rot;
  logic                  grant_found, accept;
  logic [PW-1:0]         grant_pd;
  logic [CW-1:0]         hch;
  logic [SW-1:0]         hsize;
  logic                  hready, beat_hs, pop;

  assign slot_free = !req_vld_q || mc_req_ready;
  assign ord_full  = (cnt_q == OW'(ORD_DEPTH));
  assign ord_empty = (cnt_q == '0);
  assign arb_en    = !nvdla_core_rst && slot_free && !ord_full;

  // Rotate the valid vector so the search always begins at rr_ptr+1.
  always_comb begin
    start       = (rr_ptr_q == CW'(NUM_CH-1)) ? '0 : rr_ptr_q + 1'b1;
    vld2        = {ch_req_valid, ch_req_valid};
    rot         = NUM_CH'(vld2 >> start);
    grant_found = 1'b0;
    offset      = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_found = 1'b1;
        offset      = CW'(i);
      end
    end
    sum       = {1'b0, start} + {1'b0, offset};
    grant_idx = (sum >= NCH_W) ? CW'(sum - NCH_W) : CW'(sum);
    grant_pd  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CW'(i)) grant_pd = ch_req_pd[i*PW +: PW];
    end
  end

  assign accept = arb_en && grant_found;

  always_comb begin
    ch_req_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_req_ready[i] = accept && (grant_idx == CW'(i));
    end
  end

  assign hch   = ord_ch_q[rd_ptr_q];
  assign hsize = ord_sz_q[rd_ptr_q];

  always_comb begin
    hready              = 1'b0;
    ch_rsp_valid        = '0;
    ch_cdt_lat_fifo_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hch == CW'(i)) hready = ch_rsp_ready[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rsp_valid[i]        = !nvdla_core_rst && mc_rsp_valid && !ord_empty && (hch == CW'(i));
      ch_cdt_lat_fifo_pop[i] = beat_hs && (hch == CW'(i));
    end
  end

  assign mc_rsp_ready = !nvdla_core_rst && !ord_empty && hready;
  assign beat_hs      = mc_rsp_valid && mc_rsp_ready;
  assign pop          = beat_hs && (beat_cnt_q == hsize);
  assign ch_rsp_pd    = mc_rsp_pd;
  assign mc_req_valid = req_vld_q && !nvdla_core_rst;
  assign mc_req_pd    = req_pd_q;
  assign outstanding  = cnt_q;

  always_comb begin
    req_vld_d  = req_vld_q;
    if (accept)            req_vld_d = 1'b1;
    else if (mc_req_ready) req_vld_d = 1'b0;
    rr_ptr_d   = accept ? grant_idx : rr_ptr_q;
    wr_ptr_d   = wr_ptr_q + PTRW'(accept);
    rd_ptr_d   = rd_ptr_q + PTRW'(pop);
    cnt_d      = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    beat_cnt_d = beat_cnt_q;
    if (beat_hs) beat_cnt_d = pop ? '0 : beat_cnt_q + 1'b1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      req_vld_q  <= 1'b0;
      rr_ptr_q   <= CW'(NUM_CH-1);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      req_vld_q  <= req_vld_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Payload and order storage need no reset: they are qualified by valid / occupancy.
  always_ff @(posedge nvdla_core_clk) begin
    if (accept) begin
      req_pd_q           <= grant_pd;
      ord_ch_q[wr_ptr_q] <= grant_idx;
      ord_sz_q[wr_ptr_q] <= grant_pd[PW-1:AW];
    end
  end

  // A response beat with nothing outstanding means the memory side broke ordering.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rst) assert (!(mc_rsp_valid && ord_empty));
  end

endmodule

// File: tb/tb_nvdla_rd_req_arb.sv
// Directed bench for nvdla_rd_req_arb: expected grants and beat routing are queued as
// stimulus is driven and compared by a negedge monitor when the DUT hands them off.
module tb_nvdla_rd_req_arb;
  localparam int NUM_CH = 3, AW = 32, SW = 15, RSP_W = 65, ORD_DEPTH = 8;
  localparam int PW = AW + SW, OW = $clog2(ORD_DEPTH + 1);

  logic                     clk, rst;
  logic [NUM_CH-1:0]        ch_req_valid, ch_req_ready;
  logic [NUM_CH*PW-1:0]     ch_req_pd;
  logic                     mc_req_valid, mc_req_ready;
  logic [PW-1:0]            mc_req_pd;
  logic                     mc_rsp_valid, mc_rsp_ready;
  logic [RSP_W-1:0]         mc_rsp_pd, ch_rsp_pd;
  logic [NUM_CH-1:0]        ch_rsp_valid, ch_rsp_ready, cdt_pop;
  logic [OW-1:0]            outstanding;

  logic [PW-1:0] cur_pd [NUM_CH];
  logic [PW-1:0] exp_req [$];
  int            exp_rsp [$];
  int            n_chk = 0, n_fail = 0;

  nvdla_rd_req_arb #(.NUM_CH(NUM_CH), .AW(AW), .SW(SW), .RSP_W(RSP_W), .ORD_DEPTH(ORD_DEPTH)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_pd(ch_req_pd),
    .mc_req_valid(mc_req_valid), .mc_req_ready(mc_req_ready), .mc_req_pd(mc_req_pd),
    .mc_rsp_valid(mc_rsp_valid), .mc_rsp_ready(mc_rsp_ready), .mc_rsp_pd(mc_rsp_pd),
    .ch_rsp_valid(ch_rsp_valid), .ch_rsp_ready(ch_rsp_ready), .ch_rsp_pd(ch_rsp_pd),
    .ch_cdt_lat_fifo_pop(cdt_pop), .outstanding(outstanding));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ch_req_pd[i*PW +: PW] = cur_pd[i];
  end

  function automatic logic [NUM_CH-1:0] oh(input int c);
    return NUM_CH'(1) << c;
  endfunction

  function automatic logic [PW-1:0] mk(input int ch, input int sz, input int tag);
    logic [AW-1:0] a;
    a = 32'hA000_0000 | (32'(ch) << 16) | 32'(tag);
    return {SW'(sz), a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input int n);
    int got, guard;
    got = 0;
    guard = 0;
    mc_rsp_valid = 1'b1;
    while (got < n && guard < 50) begin
      mc_rsp_pd = RSP_W'({$urandom(), $urandom(), $urandom()});
      @(negedge clk);
      if (mc_rsp_ready) got++;
      cyc();
      guard++;
    end
    mc_rsp_valid = 1'b0;
    chk("beats_delivered", 128'(got), 128'(n));
  endtask

  // Scoreboard side: compare handoffs against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (mc_req_valid && mc_req_ready) begin
        n_chk++;
        if (exp_req.size() == 0) begin
          n_fail++;
          $error("FAIL req_unexpected: observed pd 0x%0h expected no request", mc_req_pd);
        end else begin
          logic [PW-1:0] e;
          e = exp_req.pop_front();
          chk("mc_req_pd", 128'(mc_req_pd), 128'(e));
        end
      end
      if (mc_rsp_valid && mc_rsp_ready) begin
        n_chk++;
        if (exp_rsp.size() == 0) begin
          n_fail++;
          $error("FAIL rsp_unexpected: observed ch_rsp_valid 0x%0h expected no beat", ch_rsp_valid);
        end else begin
          int ec;
          ec = exp_rsp.pop_front();
          chk("rsp_route", 128'(ch_rsp_valid), 128'(oh(ec)));
          chk("cdt_pop", 128'(cdt_pop), 128'(oh(ec)));
          chk("rsp_pd", 128'(ch_rsp_pd), 128'(mc_rsp_pd));
        end
      end else begin
        chk("cdt_pop_idle", 128'(cdt_pop), 128'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ch_req_valid = '1; mc_req_ready = 1'b1;
    mc_rsp_valid = 1'b1; mc_rsp_pd = '0; ch_rsp_ready = '1;
    for (int i = 0; i < NUM_CH; i++) cur_pd[i] = mk(i, 0, i + 1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mc_req_valid", 128'(mc_req_valid), 128'(0));
    chk("rst_ch_req_ready", 128'(ch_req_ready), 128'(0));
    chk("rst_mc_rsp_ready", 128'(mc_rsp_ready), 128'(0));
    chk("rst_ch_rsp_valid", 128'(ch_rsp_valid), 128'(0));
    chk("rst_cdt_pop", 128'(cdt_pop), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    cyc();
    rst = 1'b0; mc_rsp_valid = 1'b0;

    // Round-robin: all valid, one grant per cycle until the order FIFO fills.
    for (int k = 0; k < 8; k++) begin
      exp_req.push_back(cur_pd[k % 3]);
      @(negedge clk);
      chk("rr_ready", 128'(ch_req_ready), 128'(oh(k % 3)));
      chk("rr_outstanding", 128'(outstanding), 128'(k));
      cyc();
    end
    ch_req_valid = 3'b010;
    @(negedge clk);
    chk("full_ready", 128'(ch_req_ready), 128'(0));
    chk("full_outstanding", 128'(outstanding), 128'(8));
    cyc();
    mc_rsp_valid = 1'b1;
    exp_rsp.push_back(0);
    @(negedge clk);
    chk("full_prepop_ready", 128'(ch_req_ready), 128'(0));
    chk("full_prepop_rsp_ready", 128'(mc_rsp_ready), 128'(1));
    cyc();
    mc_rsp_valid = 1'b0;
    exp_req.push_back(cur_pd[1]);
    @(negedge clk);
    chk("after_pop_ready", 128'(ch_req_ready), 128'(oh(1)));
    chk("after_pop_outstanding", 128'(outstanding), 128'(7));
    cyc();
    ch_req_valid = '0;
    foreach (exp_rsp[i]) ;
    exp_rsp.push_back(1); exp_rsp.push_back(2); exp_rsp.push_back(0); exp_rsp.push_back(1);
    exp_rsp.push_back(2); exp_rsp.push_back(0); exp_rsp.push_back(1); exp_rsp.push_back(1);
    beats(8);
    chk("drain_outstanding", 128'(outstanding), 128'(0));

    // Multi-beat routing: ch2 size 3 then ch0 size 0.
    cur_pd[2] = mk(2, 3, 16'h40);
    ch_req_valid = 3'b100;
    exp_req.push_back(cur_pd[2]);
    @(negedge clk);
    chk("mb_grant_ch2", 128'(ch_req_ready), 128'(oh(2)));
    cyc();
    cur_pd[0] = mk(0, 0, 16'h41);
    ch_req_valid = 3'b001;
    exp_req.push_back(cur_pd[0]);
    @(negedge clk);
    chk("mb_grant_ch0", 128'(ch_req_ready), 128'(oh(0)));
    cyc();
    ch_req_valid = '0;
    for (int i = 0; i < 4; i++) exp_rsp.push_back(2);
    exp_rsp.push_back(0);
    beats(5);
    chk("mb_outstanding", 128'(outstanding), 128'(0));

    // Request backpressure: slot holds its payload, no further grant.
    cur_pd[0] = mk(0, 1, 16'h50);
    ch_req_valid = 3'b001;
    mc_req_ready = 1'b0;
    exp_req.push_back(cur_pd[0]);
    @(negedge clk);
    chk("bp_first_grant", 128'(ch_req_ready), 128'(oh(0)));
    cyc();
    cur_pd[0] = mk(0, 0, 16'h51);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid_held", 128'(mc_req_valid), 128'(1));
      chk("bp_pd_held", 128'(mc_req_pd), 128'(mk(0, 1, 16'h50)));
      chk("bp_no_grant", 128'(ch_req_ready), 128'(0));
      cyc();
    end
    mc_req_ready = 1'b1;
    exp_req.push_back(cur_pd[0]);
    @(negedge clk);
    chk("bp_release_grant", 128'(ch_req_ready), 128'(oh(0)));
    cyc();
    ch_req_valid = '0;
    // Response backpressure on the head channel.
    mc_rsp_valid = 1'b1;
    ch_rsp_ready = 3'b110;
    @(negedge clk);
    chk("rbp_valid", 128'(ch_rsp_valid), 128'(oh(0)));
    chk("rbp_mc_ready", 128'(mc_rsp_ready), 128'(0));
    chk("rbp_no_pop", 128'(cdt_pop), 128'(0));
    cyc();
    ch_rsp_ready = '1;
    for (int i = 0; i < 3; i++) exp_rsp.push_back(0);
    beats(3);
    chk("rbp_outstanding", 128'(outstanding), 128'(0));

    // Simultaneous push and last-beat pop at outstanding 4.
    for (int i = 0; i < NUM_CH; i++) cur_pd[i] = mk(i, 0, 16'h60 + i);
    ch_req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      exp_req.push_back(cur_pd[(k + 1) % 3]);
      @(negedge clk);
      chk("pp_fill_ready", 128'(ch_req_ready), 128'(oh((k + 1) % 3)));
      cyc();
    end
    ch_req_valid = 3'b100;
    mc_rsp_valid = 1'b1;
    exp_req.push_back(cur_pd[2]);
    exp_rsp.push_back(1);
    @(negedge clk);
    chk("pp_ready", 128'(ch_req_ready), 128'(oh(2)));
    chk("pp_rsp_ready", 128'(mc_rsp_ready), 128'(1));
    chk("pp_outstanding_before", 128'(outstanding), 128'(4));
    cyc();
    ch_req_valid = '0;
    mc_rsp_valid = 1'b0;
    @(negedge clk);
    chk("pp_outstanding_after", 128'(outstanding), 128'(4));
    cyc();
    exp_rsp.push_back(2); exp_rsp.push_back(0); exp_rsp.push_back(1); exp_rsp.push_back(2);
    beats(4);
    chk("pp_drain", 128'(outstanding), 128'(0));

    // Reset mid-operation: 3 outstanding, head partially delivered, slot stalled.
    cur_pd[0] = mk(0, 2, 16'h70);
    cur_pd[1] = mk(1, 0, 16'h71);
    cur_pd[2] = mk(2, 0, 16'h72);
    ch_req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      exp_req.push_back(cur_pd[k]);
      @(negedge clk);
      chk("mr_fill_ready", 128'(ch_req_ready), 128'(oh(k)));
      cyc();
    end
    ch_req_valid = '0;
    mc_req_ready = 1'b0;
    exp_rsp.push_back(0);
    beats(1);
    chk("mr_outstanding_pre", 128'(outstanding), 128'(3));
    rst = 1'b1;
    ch_req_valid = '1;
    mc_rsp_valid = 1'b1;
    @(negedge clk);
    chk("mr_rst_mc_req_valid", 128'(mc_req_valid), 128'(0));
    chk("mr_rst_ch_req_ready", 128'(ch_req_ready), 128'(0));
    chk("mr_rst_mc_rsp_ready", 128'(mc_rsp_ready), 128'(0));
    chk("mr_rst_ch_rsp_valid", 128'(ch_rsp_valid), 128'(0));
    chk("mr_rst_cdt_pop", 128'(cdt_pop), 128'(0));
    cyc();
    rst = 1'b0;
    mc_rsp_valid = 1'b0;
    mc_req_ready = 1'b1;
    exp_req.delete();
    exp_rsp.delete();
    cur_pd[0] = mk(0, 2, 16'h80);
    exp_req.push_back(cur_pd[0]);
    @(negedge clk);
    chk("mr_outstanding", 128'(outstanding), 128'(0));
    chk("mr_mc_req_valid", 128'(mc_req_valid), 128'(0));
    chk("mr_ch0_priority", 128'(ch_req_ready), 128'(oh(0)));
    chk("mr_no_rsp", 128'(ch_rsp_valid), 128'(0));
    cyc();
    ch_req_valid = '0;
    for (int i = 0; i < 3; i++) exp_rsp.push_back(0);
    beats(3);
    chk("mr_drain", 128'(outstanding), 128'(0));

    cyc();
    chk("req_queue_drained", 128'(exp_req.size()), 128'(0));
    chk("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nvdla_rd_req_arb.md
# nvdla_rd_req_arb

Parametrised N-channel read-request arbiter and response router that lets several read clients of a partition share one MCIF read port. Requests are granted round-robin into a registered output slot. The granted channel and beat count are recorded in an order FIFO. In-order response beats are steered back to the originating channel, and each delivered beat raises that channel's `cdt_lat_fifo_pop`. It sits between the processor clients (for example the sdp, sdp_b and sdp_n read paths) and the memory interface.

## Interface
- NUM_CH, 3, number of client channels (2..8)
- AW, 32, address field width in request pd bits [AW-1:0]
- SW, 15, size field width in pd bits [AW+SW-1:AW]; beats per request = size+1
- RSP_W, 65, response pd width
- ORD_DEPTH, 8, order-FIFO depth (max outstanding requests, power of 2)

- nvdla_core_clk  in  1  single clock, all state on rising edge
- nvdla_core_rst  in  1  reset, synchronous, active-high
- ch_req_valid  in  NUM_CH  per-channel request valid
- ch_req_ready  out  NUM_CH  per-channel request accept
- ch_req_pd  in  NUM_CH*(AW+SW)  packed request payloads, channel i at slice i
- mc_req_valid  out  1  request to MCIF
- mc_req_ready  in  1  MCIF accept
- mc_req_pd  out  AW+SW  granted payload
- mc_rsp_valid  in  1  response beat valid
- mc_rsp_ready  out  1  response beat accept
- mc_rsp_pd  in  RSP_W  response beat
- ch_rsp_valid  out  NUM_CH  per-channel response valid
- ch_rsp_ready  in  NUM_CH  per-channel response accept
- ch_rsp_pd  out  RSP_W  response beat, broadcast to all channels
- ch_cdt_lat_fifo_pop  out  NUM_CH  one-cycle pulse per delivered beat
- outstanding  out  $clog2(ORD_DEPTH+1)  order-FIFO occupancy

## Operation
- Output slot: a one-entry register (`mc_req_valid`, `mc_req_pd`). The slot is free when `!mc_req_valid || mc_req_ready`.
- Arbitration: the grant is computed only when the slot is free and the order FIFO is not full.
  - The search starts at `rr_ptr+1` and wraps modulo NUM_CH; the first valid channel wins.
  - `ch_req_ready[g]` = 1 only for the winner; all other ready bits are 0.
- On accept (`ch_req_valid[g] && ch_req_ready[g]`):
  - load the slot with the winner's pd;
  - set `rr_ptr` = g;
  - push {g, size} into the order FIFO.
- `rr_ptr` resets to NUM_CH-1, so channel 0 has first priority after reset.
- Order-FIFO full check: use the pre-pop count. A request is refused while the FIFO is full, even if a pop occurs in the same cycle.
- Response routing: head = {hch, hsize}; `beat_cnt` counts beats already delivered for the head entry.
  - `ch_rsp_valid[hch]` = `mc_rsp_valid && !empty`; all other channels are 0.
  - `mc_rsp_ready` = `ch_rsp_ready[hch] && !empty`.
  - `ch_rsp_pd` = `mc_rsp_pd` (combinational pass-through).
- On a beat handshake:
  - pulse `ch_cdt_lat_fifo_pop[hch]`;
  - if `beat_cnt == hsize`: pop the FIFO and clear `beat_cnt`;
  - otherwise: increment `beat_cnt`.
- Empty FIFO with `mc_rsp_valid` = 1: no beat is accepted and no steering occurs. This is a protocol error; assert it in simulation.
- Push and pop in the same cycle: the occupancy count is unchanged, and both pointers advance.
- Arithmetic:
  - `beat_cnt` is SW bits.
  - FIFO pointers are $clog2(ORD_DEPTH) bits and wrap naturally.
  - The occupancy count uses one extra bit.

## Timing
- Reset values: `mc_req_valid`=0, `ch_req_ready`=0, `mc_rsp_ready`=0, `ch_rsp_valid`=0, `ch_cdt_lat_fifo_pop`=0, `outstanding`=0, `rr_ptr`=NUM_CH-1, `beat_cnt`=0, FIFO empty. `mc_req_pd` and `ch_rsp_pd` are don't-care.
- All ready/valid outputs are forced to 0 while `nvdla_core_rst` = 1.
- Reset mid-transfer: the slot and the FIFO are discarded, and nothing is delivered after reset.
- Request latency: accept in cycle t gives `mc_req_valid` = 1 in cycle t+1.
- Back-to-back throughput: 1 request per cycle while `mc_req_ready` = 1.
- Response path: 0-cycle combinational steering; 1 beat per cycle.
- `ch_cdt_lat_fifo_pop` is asserted in the same cycle as the beat handshake.
- Handshakes: standard valid/ready. `mc_req_pd` is held stable while `mc_req_valid && !mc_req_ready`.

## Test plan
- Round-robin: all 3 channels valid continuously with `mc_req_ready`=1 -> grants in order 0,1,2,0,1,2; one request per cycle; `outstanding` rises by 1 per cycle until the FIFO reaches 8.
- Outstanding limit: 8 requests issued, no responses, channel 1 still valid -> `ch_req_ready`=0 for all channels. One response completes a size-0 entry -> the next cycle is still refused (pre-pop full check); the following cycle is granted.
- Multi-beat routing: channel 2 request with size=3, then channel 0 request with size=0; 5 beats supplied -> beats 1-4 go to channel 2 with 4 `ch_cdt_lat_fifo_pop[2]` pulses, and beat 5 goes to channel 0.
- Backpressure: `mc_req_ready`=0 for 4 cycles with channel 0 valid -> `mc_req_pd` is held constant and no further grant occurs. Response-side `ch_rsp_ready[hch]`=0 -> `mc_rsp_ready`=0 and no pop pulse.
- Reset mid-operation: assert `nvdla_core_rst` with 3 outstanding requests and `beat_cnt`=1 -> the next cycle shows all outputs 0, `outstanding`=0, and channel 0 has first priority.
- Simultaneous push/pop: at `outstanding`=4, a request accept coincides with a last-beat pop -> `outstanding` stays 4, and the order of later responses is preserved.
